// File: rtl/jpeg_idct_serialize.sv
// jpeg_idct_serialize: captures 4-lane IDCT column bursts into a double-buffered 64-word store and re-emits them as indexed serial words.
// Define JPEG_IDCT_SERIALIZE_CLAMP_EN to level-shift by +128 and saturate outputs to 0..255.
module jpeg_idct_serialize #(
  parameter int BEATS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data0_i,
  input  logic [31:0] inport_data1_i,
  input  logic [31:0] inport_data2_i,
  input  logic [31:0] inport_data3_i,
  input  logic [2:0]  inport_idx_i,
  output logic        inport_ready_o,
  input  logic        outport_accept_i,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic [5:0]  outport_idx_o,
  output logic        error_o
);
  logic [31:0] mem_q [2][64];
  logic        wr_bank_q, rd_bank_q, err_q;
  logic [1:0]  full_q;
  logic [3:0]  wr_cnt_q;
  logic [5:0]  rd_cnt_q;
  logic        flush, wr_fire, wr_last, rd_fire, rd_last;
  logic [31:0] raw;
  assign flush           = rst_i | img_start_i;
  assign inport_ready_o  = ~full_q[wr_bank_q];
  assign wr_fire         = inport_valid_i & inport_ready_o;
  assign wr_last         = wr_fire & (wr_cnt_q == 4'(BEATS - 1));
  assign outport_valid_o = full_q[rd_bank_q];
  assign rd_fire         = outport_valid_o & outport_accept_i;
  assign rd_last         = rd_fire & (&rd_cnt_q);
  assign outport_idx_o   = rd_cnt_q;
  assign error_o         = err_q;
  assign raw             = mem_q[rd_bank_q][rd_cnt_q];
  // Storage is deliberately left uncleared by reset; full_q alone qualifies it.
  always_ff @(posedge clk_i)
    if (wr_fire & ~flush) begin
      mem_q[wr_bank_q][{wr_cnt_q, 2'd0}] <= inport_data0_i;
      mem_q[wr_bank_q][{wr_cnt_q, 2'd1}] <= inport_data1_i;
      mem_q[wr_bank_q][{wr_cnt_q, 2'd2}] <= inport_data2_i;
      mem_q[wr_bank_q][{wr_cnt_q, 2'd3}] <= inport_data3_i;
    end
  // Write completes only into an empty bank and reads only drain a full one, so the per-bit full_q updates never collide.
  always_ff @(posedge clk_i)
    if (flush) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      wr_cnt_q  <= 4'd0;
      rd_cnt_q  <= 6'd0;
      err_q     <= 1'b0;
    end else begin
      if (wr_fire) wr_cnt_q <= wr_cnt_q + 4'd1;
      if (wr_last) begin
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
      end
      if (rd_fire) rd_cnt_q <= rd_cnt_q + 6'd1;
      if (rd_last) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
      if ((inport_valid_i & ~inport_ready_o) | (wr_fire & (inport_idx_i != wr_cnt_q[2:0]))) err_q <= 1'b1;
    end
`ifdef JPEG_IDCT_SERIALIZE_CLAMP_EN
  logic signed [32:0] shifted;
  assign shifted        = $signed({raw[31], raw}) + 33'sd128;
  assign outport_data_o = shifted < 0 ? 32'd0 : shifted > 33'sd255 ? 32'd255 : {24'd0, shifted[7:0]};
`else
  assign outport_data_o = raw;
`endif
endmodule

// File: tb/tb_jpeg_idct_serialize.sv
// tb_jpeg_idct_serialize: directed bursts with a queue scoreboard; a negedge monitor pops on every accepted word.
module tb_jpeg_idct_serialize;
  logic        clk = 1'b0;
  logic        rst, img_start, in_valid, in_ready, accept, out_valid, error;
  logic [31:0] d0, d1, d2, d3, out_data;
  logic [2:0]  in_idx;
  logic [5:0]  out_idx;
  int          errors = 0, checks = 0;
  logic [37:0] q[$];
  logic [31:0] blk[64];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [5:0]  hold_i;
  int          vcnt;

  always #5 clk = ~clk;

  jpeg_idct_serialize #(.BEATS(16)) dut (
    .clk_i(clk), .rst_i(rst), .img_start_i(img_start),
    .inport_valid_i(in_valid), .inport_data0_i(d0), .inport_data1_i(d1),
    .inport_data2_i(d2), .inport_data3_i(d3), .inport_idx_i(in_idx),
    .inport_ready_o(in_ready), .outport_accept_i(accept),
    .outport_valid_o(out_valid), .outport_data_o(out_data),
    .outport_idx_o(out_idx), .error_o(error)
  );

  function automatic logic [31:0] exp_out(input logic [31:0] r);
    longint v;
    v = longint'(signed'(r)) + 128;
`ifdef JPEG_IDCT_SERIALIZE_CLAMP_EN
    return v < 0 ? 32'd0 : v > 255 ? 32'd255 : 32'(v);
`else
    return r;
`endif
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 64; i++) blk[i] = base + 32'(i);
  endtask

  task automatic send(input bit push);
    if (push) for (int i = 0; i < 64; i++) q.push_back({6'(i), exp_out(blk[i])});
    for (int b = 0; b < 16; b++) begin
      in_valid = 1'b1;
      d0 = blk[4*b]; d1 = blk[4*b+1]; d2 = blk[4*b+2]; d3 = blk[4*b+3];
      in_idx = 3'(b);
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string n);
    int c;
    c = 0;
    while (out_valid && c < 200) begin
      tick;
      c++;
    end
    chk(n, 32'(out_valid), 32'd0);
    chk({n, "_sb_empty"}, 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [37:0] e;
    if (hold_v) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== hold_i || out_data !== hold_d) begin
        errors++;
        $display("FAIL hold: got v=%b idx=%0d data=%h expected v=1 idx=%0d data=%h", out_valid, out_idx, out_data, hold_i, hold_d);
      end
    end
    hold_v = !rst && !img_start && out_valid && !accept;
    hold_i = out_idx;
    hold_d = out_data;
    if (!rst && !img_start && out_valid && accept) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL word: got idx=%0d data=%h expected no output", out_idx, out_data);
      end else begin
        e = q.pop_front();
        if ({out_idx, out_data} !== e) begin
          errors++;
          $display("FAIL word: got idx=%0d data=%h expected idx=%0d data=%h", out_idx, out_data, e[37:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; img_start = 1'b0; in_valid = 1'b0; accept = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; in_idx = '0;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_error", 32'(error), 32'd0);
    // single block streamed straight through
    accept = 1'b1;
    fill(32'h1000);
    send(1'b1);
    chk("t1_lat_valid", 32'(out_valid), 32'd1);
    chk("t1_lat_idx", 32'(out_idx), 32'd0);
    drain("t1_drain");
    chk("t1_error", 32'(error), 32'd0);
    // both banks full, third burst dropped
    accept = 1'b0;
    fill(32'h2000);
    send(1'b1);
    fill(32'h3000);
    send(1'b1);
    chk("t2_ready_full", 32'(in_ready), 32'd0);
    chk("t2_error_pre", 32'(error), 32'd0);
    fill(32'h4000);
    send(1'b0);
    chk("t2_error_drop", 32'(error), 32'd1);
    accept = 1'b1;
    drain("t2_drain");
    chk("t2_ready_after", 32'(in_ready), 32'd1);
    chk("t2_error_sticky", 32'(error), 32'd1);
    img_start = 1'b1;
    tick;
    img_start = 1'b0;
    chk("t2_error_clear", 32'(error), 32'd0);
    // accept toggling every cycle
    accept = 1'b0;
    fill(32'h8000);
    send(1'b1);
    vcnt = 0;
    for (int i = 0; i < 128; i++) begin
      accept = i[0];
      @(negedge clk);
      if (out_valid) vcnt++;
      tick;
    end
    accept = 1'b0;
    chk("t3_cycles", 32'(vcnt), 32'd128);
    chk("t3_done", 32'(out_valid), 32'd0);
    // bank 1 completes on the cycle bank 0 hands over idx 63
    fill(32'h9000);
    send(1'b1);
    accept = 1'b1;
    repeat (48) tick;
    chk("t4_idx48", 32'(out_idx), 32'd48);
    fill(32'hA000);
    send(1'b1);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_idx", 32'(out_idx), 32'd0);
    chk("t4_data", out_data, exp_out(32'hA000));
    chk("t4_ready", 32'(in_ready), 32'd1);
    drain("t4_drain");
    // img_start mid-burst after mismatched indices
    accept = 1'b0;
    fill(32'hB000);
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1;
      d0 = blk[4*b]; d1 = blk[4*b+1]; d2 = blk[4*b+2]; d3 = blk[4*b+3];
      in_idx = 3'(b + 1);
      tick;
    end
    chk("t5_error_idx", 32'(error), 32'd1);
    in_idx = 3'd7;
    img_start = 1'b1;
    tick;
    img_start = 1'b0;
    in_valid = 1'b0;
    chk("t5a_valid", 32'(out_valid), 32'd0);
    chk("t5a_ready", 32'(in_ready), 32'd1);
    chk("t5a_error", 32'(error), 32'd0);
    // img_start mid-read
    fill(32'hC000);
    send(1'b1);
    accept = 1'b1;
    repeat (30) tick;
    chk("t5b_idx30", 32'(out_idx), 32'd30);
    accept = 1'b0;
    img_start = 1'b1;
    tick;
    img_start = 1'b0;
    q.delete();
    chk("t5b_valid", 32'(out_valid), 32'd0);
    chk("t5b_ready", 32'(in_ready), 32'd1);
    chk("t5b_error", 32'(error), 32'd0);
    chk("t5b_idx", 32'(out_idx), 32'd0);
    accept = 1'b1;
    fill(32'hD000);
    send(1'b1);
    drain("t5_fresh_drain");
    // clamp boundary words (raw when the clamp is not built)
    fill(32'h7000);
    blk[0] = 32'hFFFFFF00;
    blk[1] = 32'h00000000;
    blk[2] = 32'h0000007F;
    blk[3] = 32'h00000100;
    send(1'b1);
    drain("t6_drain");
    chk("final_error", 32'(error), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
